// File: rtl/pipelined_compare_unit.sv
`default_nettype none
// ============================================================================
// pipelined_compare_unit : two-stage signed/unsigned comparator + MIN/MAX select
// Rev 1.0
// ============================================================================
module pipelined_compare_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sig,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_eq,
    output logic             out_lt,
    output logic             out_gt,
    output logic             out_cond,
    output logic [WIDTH-1:0] out_value,
    output logic [TAG_W-1:0] out_tag
);

    localparam int C_NIB = WIDTH / 4;
    localparam int C_LVL = $clog2(C_NIB);

    localparam logic [2:0] C_OP_EQ  = 3'b000;
    localparam logic [2:0] C_OP_NE  = 3'b001;
    localparam logic [2:0] C_OP_LT  = 3'b010;
    localparam logic [2:0] C_OP_GE  = 3'b011;
    localparam logic [2:0] C_OP_GT  = 3'b100;
    localparam logic [2:0] C_OP_LE  = 3'b101;
    localparam logic [2:0] C_OP_MIN = 3'b110;

    // Flow control
    logic w_s1_adv, w_s2_adv, w_take;
    logic r_s1_valid, r_s2_valid;

    assign w_s2_adv = ~r_s2_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv & ~flush;
    assign w_take   = in_valid & in_ready;

    // Stage 1: per-nibble unsigned compare
    logic [C_NIB-1:0] w_nib_eq, w_nib_gt;

    generate
        for (genvar gi = 0; gi < C_NIB; gi++) begin : g_nib
            assign w_nib_eq[gi] = (in_a[4*gi +: 4] == in_b[4*gi +: 4]);
            assign w_nib_gt[gi] = (in_a[4*gi +: 4] >  in_b[4*gi +: 4]);
        end
    endgenerate

    logic [C_NIB-1:0] r_s1_eq, r_s1_gt;
    logic [WIDTH-1:0] r_s1_a, r_s1_b;
    logic             r_s1_a_msb, r_s1_b_msb, r_s1_sig;
    logic [2:0]       r_s1_op;
    logic [TAG_W-1:0] r_s1_tag;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
        end else begin
            if (flush)
                r_s1_valid <= 1'b0;
            else if (w_s1_adv)
                r_s1_valid <= in_valid;
            if (w_take) begin
                r_s1_eq    <= w_nib_eq;
                r_s1_gt    <= w_nib_gt;
                r_s1_a     <= in_a;
                r_s1_b     <= in_b;
                r_s1_a_msb <= in_a[WIDTH-1];
                r_s1_b_msb <= in_b[WIDTH-1];
                r_s1_sig   <= in_sig;
                r_s1_op    <= in_op;
                r_s1_tag   <= in_tag;
            end
        end
    end

    // Stage 2: pairwise tree reduction, done in place (upper half folds into lower)
    logic [C_NIB-1:0] w_red_eq, w_red_gt;

    always_comb begin
        w_red_eq = r_s1_eq;
        w_red_gt = r_s1_gt;
        for (int l = 0; l < C_LVL; l++) begin
            for (int i = 0; i < (C_NIB >> (l + 1)); i++) begin
                w_red_gt[i] = w_red_gt[2*i+1] | (w_red_eq[2*i+1] & w_red_gt[2*i]);
                w_red_eq[i] = w_red_eq[2*i+1] & w_red_eq[2*i];
            end
        end
    end

    logic             w_sdiff, w_eq, w_gt, w_lt, w_cond;
    logic [WIDTH-1:0] w_value;

    // Differing sign bits under signed compare: the negative operand is smaller
    assign w_sdiff = r_s1_sig & (r_s1_a_msb ^ r_s1_b_msb);
    assign w_eq    = w_red_eq[0];
    assign w_gt    = w_sdiff ? r_s1_b_msb : w_red_gt[0];
    assign w_lt    = w_sdiff ? r_s1_a_msb : (~w_eq & ~w_red_gt[0]);

    always_comb begin
        w_value = r_s1_a;
        case (r_s1_op)
            C_OP_EQ:  w_cond = w_eq;
            C_OP_NE:  w_cond = ~w_eq;
            C_OP_LT:  w_cond = w_lt;
            C_OP_GE:  w_cond = ~w_lt;
            C_OP_GT:  w_cond = w_gt;
            C_OP_LE:  w_cond = ~w_gt;
            C_OP_MIN: begin
                w_cond  = w_lt;
                w_value = w_lt ? r_s1_a : r_s1_b;
            end
            default: begin
                w_cond  = w_gt;
                w_value = w_gt ? r_s1_a : r_s1_b;
            end
        endcase
    end

    logic             r_eq, r_lt, r_gt, r_cond;
    logic [WIDTH-1:0] r_value;
    logic [TAG_W-1:0] r_tag;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_eq       <= 1'b0;
            r_lt       <= 1'b0;
            r_gt       <= 1'b0;
            r_cond     <= 1'b0;
            r_value    <= '0;
            r_tag      <= '0;
        end else begin
            if (flush)
                r_s2_valid <= 1'b0;
            else if (w_s2_adv)
                r_s2_valid <= r_s1_valid;
            if (w_s2_adv && r_s1_valid) begin
                r_eq    <= w_eq;
                r_lt    <= w_lt;
                r_gt    <= w_gt;
                r_cond  <= w_cond;
                r_value <= w_value;
                r_tag   <= r_s1_tag;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_eq    = r_eq;
    assign out_lt    = r_lt;
    assign out_gt    = r_gt;
    assign out_cond  = r_cond;
    assign out_value = r_value;
    assign out_tag   = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_compare_unit.sv
`default_nettype none
// ============================================================================
// tb_pipelined_compare_unit : WIDTH 8/32/64 instances against an arithmetic model
// Rev 1.0
// ============================================================================
module tb_pipelined_compare_unit;

    localparam int WD [3] = '{8, 32, 64};

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, out_ready, in_sig;
    logic [2:0]  in_op;
    logic [3:0]  in_tag;
    logic [63:0] ia [3];
    logic [63:0] ib [3];

    logic [2:0]  ir, ov, o_eq, o_lt, o_gt, o_cond;
    logic [3:0]  tg [3];
    logic [7:0]  v8;
    logic [31:0] v32;
    logic [63:0] v64;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_compare_unit #(.WIDTH(8), .TAG_W(4)) u_w8 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_a(ia[0][7:0]), .in_b(ib[0][7:0]), .in_sig(in_sig), .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(out_ready), .out_eq(o_eq[0]), .out_lt(o_lt[0]),
        .out_gt(o_gt[0]), .out_cond(o_cond[0]), .out_value(v8), .out_tag(tg[0]));

    pipelined_compare_unit #(.WIDTH(32), .TAG_W(4)) u_w32 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_a(ia[1][31:0]), .in_b(ib[1][31:0]), .in_sig(in_sig), .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(out_ready), .out_eq(o_eq[1]), .out_lt(o_lt[1]),
        .out_gt(o_gt[1]), .out_cond(o_cond[1]), .out_value(v32), .out_tag(tg[1]));

    pipelined_compare_unit #(.WIDTH(64), .TAG_W(4)) u_w64 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_a(ia[2]), .in_b(ib[2]), .in_sig(in_sig), .in_op(in_op), .in_tag(in_tag),
        .out_valid(ov[2]), .out_ready(out_ready), .out_eq(o_eq[2]), .out_lt(o_lt[2]),
        .out_gt(o_gt[2]), .out_cond(o_cond[2]), .out_value(v64), .out_tag(tg[2]));

    typedef struct {
        logic [2:0][63:0] a;
        logic [2:0][63:0] b;
        logic             sig;
        logic [2:0]       op;
        logic [3:0]       tag;
        int               acc;
    } item_t;

    item_t q [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] dut_val(input int d);
        if (d == 0) return {56'h0, v8};
        if (d == 1) return {32'h0, v32};
        return v64;
    endfunction

    function automatic logic [3:0] dut_fl(input int d);
        return {o_eq[d], o_lt[d], o_gt[d], o_cond[d]};
    endfunction

    // Reference: treat operands as w-bit integers (sign-extended when signed)
    function automatic void model(input int w, input logic s, input logic [2:0] op,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [3:0] fl, output logic [63:0] v);
        logic signed [64:0] xa, xb;
        logic eq, lt, gt, c;
        xa = {1'b0, a};
        xb = {1'b0, b};
        if (s && a[w-1]) xa = xa | ~((65'd1 << w) - 65'd1);
        if (s && b[w-1]) xb = xb | ~((65'd1 << w) - 65'd1);
        eq = (xa == xb);
        lt = (xa < xb);
        gt = (xa > xb);
        case (op)
            3'd0: c = eq;
            3'd1: c = !eq;
            3'd2: c = lt;
            3'd3: c = !lt;
            3'd4: c = gt;
            3'd5: c = !gt;
            3'd6: c = lt;
            default: c = gt;
        endcase
        v  = (op == 3'd6) ? (lt ? a : b) : (op == 3'd7) ? (gt ? a : b) : a;
        fl = {eq, lt, gt, c};
    endfunction

    function automatic logic [63:0] gen(input int w);
        logic [63:0] m, r;
        m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: r = 64'd0;
            1: r = m;
            2: r = 64'd1 << (w - 1);
            3: r = (64'd1 << (w - 1)) - 64'd1;
            4: r = (64'd1 << (w - 1)) + 64'd1;
            default: ;
        endcase
        return r & m;
    endfunction

    task automatic drive_rand();
        in_sig = 1'($urandom_range(0, 1));
        in_op  = 3'($urandom_range(0, 7));
        in_tag = 4'($urandom_range(0, 15));
        for (int d = 0; d < 3; d++) begin
            ia[d] = gen(WD[d]);
            ib[d] = ($urandom_range(0, 7) == 0) ? ia[d] : gen(WD[d]);
        end
    endtask

    // Scoreboard: occupancy and age of the oldest op give in_ready/out_valid
    always @(negedge clk) begin
        logic        exp_ir, exp_ov;
        logic [3:0]  efl;
        logic [63:0] ev;
        item_t       it;
        if (!reset_n) begin
            q.delete();
        end else begin
            exp_ir = !flush && (q.size() < 2 || out_ready);
            exp_ov = (q.size() > 0) ? (cyc >= q[0].acc + 2) : 1'b0;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("w%0d.in_ready", WD[d]), 64'(ir[d]), 64'(exp_ir));
                chk($sformatf("w%0d.out_valid", WD[d]), 64'(ov[d]), 64'(exp_ov));
                if (exp_ov) begin
                    model(WD[d], q[0].sig, q[0].op, q[0].a[d], q[0].b[d], efl, ev);
                    chk($sformatf("w%0d.flags", WD[d]), 64'(dut_fl(d)), 64'(efl));
                    chk($sformatf("w%0d.value", WD[d]), dut_val(d), ev);
                    chk($sformatf("w%0d.tag", WD[d]), 64'(tg[d]), 64'(q[0].tag));
                end
            end
            if (exp_ov && out_ready) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (in_valid && exp_ir) begin
                for (int d = 0; d < 3; d++) begin
                    it.a[d] = ia[d];
                    it.b[d] = ib[d];
                end
                it.sig = in_sig;
                it.op  = in_op;
                it.tag = in_tag;
                it.acc = cyc;
                q.push_back(it);
            end
        end
    end

    task automatic check_reset_state(input string nm);
        for (int d = 0; d < 3; d++) begin
            chk({nm, ".in_ready"}, 64'(ir[d]), 64'd1);
            chk({nm, ".out_valid"}, 64'(ov[d]), 64'd0);
            chk({nm, ".flags"}, 64'(dut_fl(d)), 64'd0);
            chk({nm, ".value"}, dut_val(d), 64'd0);
            chk({nm, ".tag"}, 64'(tg[d]), 64'd0);
        end
    endtask

    task automatic run_dir(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [2:0] op, input logic [3:0] t,
                           input logic [3:0] efl, input logic [31:0] ev);
        @(posedge clk); #1;
        out_ready = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        ia[0] = {56'h0, a[7:0]};
        ib[0] = {56'h0, b[7:0]};
        ia[1] = {32'h0, a};
        ib[1] = {32'h0, b};
        ia[2] = {32'h0, a};
        ib[2] = {32'h0, b};
        in_sig = s;
        in_op  = op;
        in_tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({nm, ".valid"}, 64'(ov[1]), 64'd1);
        chk({nm, ".flags"}, 64'(dut_fl(1)), 64'(efl));
        chk({nm, ".value"}, {32'h0, v32}, {32'h0, ev});
        chk({nm, ".tag"}, 64'(tg[1]), 64'(t));
    endtask

    initial begin
        int  idx;
        bit  need_new;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_sig    = 1'b0;
        in_op     = 3'd0;
        in_tag    = 4'd0;
        for (int d = 0; d < 3; d++) begin
            ia[d] = 64'd0;
            ib[d] = 64'd0;
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_reset_state("reset");

        // flags are {eq, lt, gt, cond}
        run_dir("gt_u",   32'h80000000, 32'h7FFFFFFF, 1'b0, 3'd4, 4'd3, 4'b0011, 32'h80000000);
        run_dir("lt_s",   32'h80000000, 32'h7FFFFFFF, 1'b1, 3'd2, 4'd4, 4'b0101, 32'h80000000);
        run_dir("ne_eq",  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'd1, 4'd5, 4'b1000, 32'hDEADBEEF);
        run_dir("min_s",  32'hFFFFFFFE, 32'h00000005, 1'b1, 3'd6, 4'd6, 4'b0101, 32'hFFFFFFFE);
        run_dir("max_s",  32'hFFFFFFFE, 32'h00000005, 1'b1, 3'd7, 4'd7, 4'b0100, 32'h00000005);
        run_dir("min_u",  32'hFFFFFFFE, 32'h00000005, 1'b0, 3'd6, 4'd8, 4'b0010, 32'h00000005);
        run_dir("max_eq", 32'h12345678, 32'h12345678, 1'b1, 3'd7, 4'd9, 4'b1000, 32'h12345678);

        // Backpressure: four back-to-back ops, consumer stalls for five cycles
        idx      = 0;
        need_new = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            out_ready = !(k >= 2 && k < 7);
            if (idx < 4) begin
                if (need_new) begin
                    drive_rand();
                    in_tag   = 4'(idx);
                    need_new = 1'b0;
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k == 5) begin
                chk("bp.hold_tag", 64'(tg[1]), 64'd0);
                chk("bp.in_ready", 64'(ir[1]), 64'd0);
            end
            if (in_valid && ir[1]) begin
                idx++;
                need_new = 1'b1;
            end
        end

        // Flush with two ops in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive_rand();
        in_tag   = 4'd10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive_rand();
        in_tag = 4'd11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush.out_valid", 64'(ov[1]), 64'd0);
        end

        // Reset with two ops in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive_rand();
        in_tag   = 4'd12;
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive_rand();
        in_tag = 4'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b1;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        reset_n   = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_reset_state("midreset");

        // Random traffic across all widths, ops and flow-control patterns
        for (int k = 0; k < 10000; k++) begin
            @(posedge clk); #1;
            reset_n   = ($urandom_range(0, 999) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive_rand();
        end
        @(posedge clk); #1;
        reset_n   = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_compare_unit.md
Name: pipelined_compare_unit

Overview:
Parametrised, pipelined successor to the CPU's single-cycle 32-bit comparator. It evaluates signed or unsigned relations between two WIDTH-bit operands using a chunked tree reduction with registered stages. It also resolves a selectable condition code (branch conditions plus MIN/MAX). Sits between the register-read stage and the branch/ALU writeback logic, with valid/ready flow control, backpressure and flush.

Parameters:
WIDTH, 32, operand width; must be 8, 16, 32 or 64 (WIDTH/4 is a power of two).
TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_n  in  1  synchronous reset, active low.
flush  in  1  synchronous pipeline kill.
in_valid  in  1  operation present on input.
in_ready  out  1  unit accepts input this cycle.
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
in_sig  in  1  1 = signed two's-complement compare, 0 = unsigned.
in_op  in  3  000 EQ, 001 NE, 010 LT, 011 GE, 100 GT, 101 LE, 110 MIN, 111 MAX.
in_tag  in  TAG_W  sideband, returned unchanged.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts result.
out_eq  out  1  A == B.
out_lt  out  1  A < B under in_sig.
out_gt  out  1  A > B under in_sig.
out_cond  out  1  condition selected by op is true.
out_value  out  WIDTH  MIN/MAX result; for ops 000-101 equals A.
out_tag  out  TAG_W  tag of this result.

Behaviour:
- Two register stages; latency exactly 2 cycles from accepted input to out_valid when not stalled. Throughput 1 op/cycle.
- Stage 1 (S1): split operands into WIDTH/4 nibbles and register per-nibble eq and a_gt (unsigned) vectors. Also register a[WIDTH-1], b[WIDTH-1], A, B, sig, op and tag.
- Stage 2 (S2): reduce in log2(WIDTH/4) pairwise levels. Combine rule: eq = eq_hi & eq_lo; gt = gt_hi | (eq_hi & gt_lo).
- Signed fix-up when sig=1 and the sign bits differ: gt = b_sign, lt = a_sign.
- Otherwise lt = ~eq & ~gt.
- Exactly one of eq/lt/gt is 1 whenever out_valid=1.
- out_cond per op:
  - EQ eq; NE ~eq; LT lt; GE ~lt; GT gt; LE ~gt.
  - MIN lt, with out_value = lt ? A : B.
  - MAX gt, with out_value = gt ? A : B.
  - Equal operands under MIN/MAX return B (bit-identical to A).
- Flow control, no bubbles required:
  - s2_adv = ~s2_valid | out_ready
  - s1_adv = ~s1_valid | s2_adv
  - in_ready = s1_adv & ~flush
- A transfer occurs on in_valid & in_ready; out_valid & out_ready retires the S2 result.
- While out_valid=1 and out_ready=0, all out_* signals hold stable. A valid S1 entry stays held, and in_ready=0 once S1 is also occupied.
- in_ready depends combinationally on out_ready; no other comb path runs input to output.
- flush=1: S1 and S2 valid bits clear on the next edge. Any input presented that cycle is dropped, since in_ready is forced 0. Data registers need not clear.
- Reset (reset_n=0 at an edge): s1_valid, s2_valid and out_valid = 0. out_eq/lt/gt/cond = 0, out_value = 0, out_tag = 0. in_ready is 1 in the first cycle after reset release. Reset mid-operation discards all in-flight ops; reset has priority over flush.
- Data registers load only when their stage advances. Stalled stages hold their contents, and no op is lost or duplicated.

Test Plan:
- Unsigned, WIDTH=32: A=0x80000000, B=0x7FFFFFFF, sig=0, op=GT, tag=3 -> 2 cycles later out_gt=1, out_cond=1, out_tag=3.
- Same operands with sig=1, op=LT -> out_lt=1, out_cond=1, out_gt=0. Then A=B=0xDEADBEEF, op=NE -> out_eq=1, out_cond=0.
- MIN/MAX, signed: A=0xFFFFFFFE (-2), B=0x00000005, op=MIN -> out_value=0xFFFFFFFE; op=MAX -> out_value=0x00000005. Unsigned MIN of the same operands -> out_value=0x00000005.
- Backpressure: stream 4 ops with tags 0-3 and hold out_ready=0 from cycle 3 for 5 cycles. Required: in_ready falls to 0, outputs stay stable for tag 0, and tags 0-3 emerge in order once released, with none dropped.
- Flush and reset: 2 ops in flight, then flush=1 for 1 cycle -> out_valid=0 next cycle and neither tag appears. Repeat with reset_n=0 -> all outputs 0 and in_ready=1 after release.
- Parameter sweep with WIDTH=8 and WIDTH=64: random signed/unsigned ops, all 8 opcodes, 10k vectors versus a behavioural model -> zero mismatches. Include boundaries 0, all-ones, MSB-only and MSB-1.
